// File: rtl/reg_writeback_scoreboard_pkg.sv
// Shared sizing constants and register-address helpers for the write-back scoreboard.
// Only addresses 1..NREGS-1 are ever tracked as busy.
package reg_writeback_scoreboard_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 16;
    localparam int MAX_LD     = 4;
    localparam int REG_ADDR_W = 5;
    localparam int REG_IDX_W  = $clog2(NREGS);
    localparam int LD_CNT_W   = $clog2(MAX_LD + 1);

    localparam logic [REG_ADDR_W-1:0] X0         = '0;
    localparam logic [REG_ADDR_W-1:0] NREGS_ADDR = REG_ADDR_W'(NREGS);
    localparam logic [LD_CNT_W-1:0]   LD_CNT_MAX = LD_CNT_W'(MAX_LD);

    function automatic logic in_range(input logic [REG_ADDR_W-1:0] addr);
        return addr < NREGS_ADDR;
    endfunction

    function automatic logic reg_busy(input logic [NREGS-1:0]      busy,
                                      input logic [REG_ADDR_W-1:0] addr);
        return in_range(addr) && busy[addr[REG_IDX_W-1:0]];
    endfunction

    // One-hot busy mask for a destination; zero for x0 and unimplemented registers.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NREGS-1:0] v;
        v = '0;
        if (in_range(addr) && addr != X0) begin
            v[addr[REG_IDX_W-1:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_writeback_scoreboard_wb_arbiter.sv
// Fixed-priority select between the ALU result (never stalls) and the load result.
// The load side is only acknowledged when the ALU is silent.
module wb_arbiter
    import reg_writeback_scoreboard_pkg::*;
(
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_ld_valid,
    input  logic [REG_ADDR_W-1:0] i_ld_rd,
    input  logic [XLEN-1:0]       i_ld_data,
    output logic                  o_sel_valid,
    output logic [REG_ADDR_W-1:0] o_sel_rd,
    output logic [XLEN-1:0]       o_sel_data,
    output logic                  o_ld_ready
);

    assign o_ld_ready  = !i_alu_valid;
    assign o_sel_valid = i_alu_valid || i_ld_valid;
    assign o_sel_rd    = i_alu_valid ? i_alu_rd   : i_ld_rd;
    assign o_sel_data  = i_alu_valid ? i_alu_data : i_ld_data;

endmodule

// File: rtl/reg_writeback_scoreboard.sv
// Register write-back scoreboard: tracks busy destinations and outstanding loads,
// stalls hazardous issue, and drives the registered regfile write port.
module reg_writeback_scoreboard
    import reg_writeback_scoreboard_pkg::*;
(
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_wr_rd,
    input  logic                  issue_is_load,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  WE3,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [XLEN-1:0]       WD3,
    output logic [NREGS-1:0]      busy_vec,
    output logic                  idle
);

    logic [NREGS-1:0]      r_busy;
    logic [LD_CNT_W-1:0]   r_ld_cnt;
    logic                  r_we3;
    logic [REG_ADDR_W-1:0] r_a3;
    logic [XLEN-1:0]       r_wd3;

    logic                  w_sel_valid;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_hazard;
    logic                  w_issue_fire;
    logic                  w_ld_issue;
    logic                  w_ld_hs;
    logic [NREGS-1:0]      w_busy_set;
    logic [NREGS-1:0]      w_busy_clr;

    wb_arbiter u_wb_arbiter (
        .i_alu_valid (alu_valid),
        .i_alu_rd    (alu_rd),
        .i_alu_data  (alu_data),
        .i_ld_valid  (ld_valid),
        .i_ld_rd     (ld_rd),
        .i_ld_data   (ld_data),
        .o_sel_valid (w_sel_valid),
        .o_sel_rd    (w_sel_rd),
        .o_sel_data  (w_sel_data),
        .o_ld_ready  (ld_ready)
    );

    // Hazards look only at pre-edge busy state, so a same-cycle clear still stalls.
    always_comb begin
        // NOTE: default first so every path assigns w_hazard and no latch is inferred.
        w_hazard = 1'b0;
        if (issue_use_rs1 && reg_busy(r_busy, issue_rs1))                  w_hazard = 1'b1;
        if (issue_use_rs2 && reg_busy(r_busy, issue_rs2))                  w_hazard = 1'b1;
        if (issue_wr_rd && issue_rd != X0 && reg_busy(r_busy, issue_rd))   w_hazard = 1'b1;
        if (issue_is_load && r_ld_cnt == LD_CNT_MAX)                       w_hazard = 1'b1;
    end

    assign issue_ready  = !w_hazard;
    assign w_issue_fire = issue_valid && !w_hazard;
    assign w_ld_issue   = w_issue_fire && issue_is_load;
    assign w_ld_hs      = ld_valid && ld_ready;
    assign w_busy_set   = (w_issue_fire && issue_wr_rd) ? reg_onehot(issue_rd) : '0;
    assign w_busy_clr   = w_sel_valid ? reg_onehot(w_sel_rd) : '0;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_busy   <= '0;
            r_ld_cnt <= '0;
            r_we3    <= 1'b0;
            r_a3     <= '0;
            r_wd3    <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples the same pre-edge values.
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
            if (w_ld_issue && !w_ld_hs) begin
                r_ld_cnt <= r_ld_cnt + LD_CNT_W'(1);
            end else if (!w_ld_issue && w_ld_hs) begin
                r_ld_cnt <= r_ld_cnt - LD_CNT_W'(1);
            end
            r_we3 <= w_sel_valid;
            if (w_sel_valid) begin
                r_a3  <= w_sel_rd;
                r_wd3 <= w_sel_data;
            end
        end
    end

    assign WE3      = r_we3;
    assign A3       = r_a3;
    assign WD3      = r_wd3;
    assign busy_vec = r_busy;
    assign idle     = (r_busy == '0) && (r_ld_cnt == '0) && !r_we3;

    a_ld_underflow: assert property (@(posedge CLK) disable iff (reset)
        !(w_ld_hs && r_ld_cnt == '0))
        else $error("load handshake with no outstanding load");

    a_spurious_completion: assert property (@(posedge CLK) disable iff (reset)
        !(w_sel_valid && ((w_busy_clr & ~r_busy) != '0)))
        else $warning("completion to a register that is not busy");

endmodule

// File: tb/tb_reg_writeback_scoreboard.sv
// Self-checking bench: directed hazard/arbitration scenarios plus random traffic,
// compared each cycle against a set/queue model of the scoreboard rules.
module tb_reg_writeback_scoreboard;
    import reg_writeback_scoreboard_pkg::*;

    localparam int M_NREGS  = 16;
    localparam int M_MAX_LD = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_use_rs1, issue_use_rs2, issue_wr_rd, issue_is_load;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [15:0] busy_vec;
    logic        idle;

    int errors = 0;
    int checks = 0;

    // Reference model: set of busy registers, outstanding-load count, last write.
    logic [31:0] m_busy;
    int          m_cnt;
    logic        m_we;
    logic [4:0]  m_a;
    logic [31:0] m_wd;
    int          pend_alu[$];
    int          pend_ld[$];

    reg_writeback_scoreboard dut (
        .CLK           (CLK),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_wr_rd   (issue_wr_rd),
        .issue_is_load (issue_is_load),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .WE3           (WE3),
        .A3            (A3),
        .WD3           (WD3),
        .busy_vec      (busy_vec),
        .idle          (idle)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic wr, input logic ld);
        issue_valid   = v;
        issue_rs1     = rs1;
        issue_use_rs1 = u1;
        issue_rs2     = rs2;
        issue_use_rs2 = u2;
        issue_rd      = rd;
        issue_wr_rd   = wr;
        issue_is_load = ld;
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_cnt  = 0;
        m_we   = 1'b0;
        m_a    = '0;
        m_wd   = '0;
        pend_alu.delete();
        pend_ld.delete();
    endtask

    // One clock: called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        logic       hz, fire, hs, sel;
        logic [4:0] srd;
        logic [31:0] sdata;
        #1;
        hz = (issue_use_rs1 && m_busy[issue_rs1]) || (issue_use_rs2 && m_busy[issue_rs2]) ||
             (issue_wr_rd && issue_rd != 0 && m_busy[issue_rd]) ||
             (issue_is_load && m_cnt == M_MAX_LD);
        check("issue_ready", 32'(issue_ready), 32'(!hz));
        check("ld_ready", 32'(ld_ready), 32'(!alu_valid));
        check("idle", 32'(idle), 32'(m_busy == 0 && m_cnt == 0 && !m_we));

        fire  = issue_valid && !hz;
        hs    = ld_valid && !alu_valid;
        sel   = alu_valid || ld_valid;
        srd   = alu_valid ? alu_rd : ld_rd;
        sdata = alu_valid ? alu_data : ld_data;
        if (sel) m_busy[srd] = 1'b0;
        if (fire && issue_wr_rd && issue_rd != 0 && issue_rd < M_NREGS) m_busy[issue_rd] = 1'b1;
        if (fire && issue_is_load) m_cnt++;
        if (hs) m_cnt--;
        m_we = sel;
        if (sel) begin
            m_a  = srd;
            m_wd = sdata;
        end

        if (fire && issue_is_load) pend_ld.push_back(int'(issue_rd));
        else if (fire && issue_wr_rd) pend_alu.push_back(int'(issue_rd));
        if (alu_valid) begin
            for (int i = 0; i < pend_alu.size(); i++) begin
                if (pend_alu[i] == int'(alu_rd)) begin
                    pend_alu.delete(i);
                    break;
                end
            end
        end
        if (hs) void'(pend_ld.pop_front());

        @(posedge CLK);
        #1;
        check("WE3", 32'(WE3), 32'(m_we));
        check("A3", 32'(A3), 32'(m_a));
        check("WD3", WD3, m_wd);
        check("busy_vec", 32'(busy_vec), {16'b0, m_busy[15:0]});
        if (hs) ld_valid = 1'b0;
        @(negedge CLK);
    endtask

    // Stop issuing and return every owed result; then let WE3 drop.
    task automatic drain();
        int n;
        n = 0;
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);
        while ((pend_alu.size() != 0 || pend_ld.size() != 0 || ld_valid) && n < 500) begin
            alu_valid = 1'b0;
            if (pend_alu.size() != 0 && $urandom_range(0, 1) == 1) begin
                alu_valid = 1'b1;
                alu_rd    = 5'(pend_alu[0]);
                alu_data  = $urandom;
            end
            if (!ld_valid && pend_ld.size() != 0) begin
                ld_valid = 1'b1;
                ld_rd    = 5'(pend_ld[0]);
                ld_data  = $urandom;
            end
            cycle();
            n++;
        end
        alu_valid = 1'b0;
        check("drain bounded", 32'(n < 500), 32'd1);
        cycle();
        check("idle after drain", 32'(idle), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check("reset WE3", 32'(WE3), 32'd0);
        check("reset A3", 32'(A3), 32'd0);
        check("reset WD3", WD3, 32'd0);
        check("reset busy_vec", 32'(busy_vec), 32'd0);
        check("reset idle", 32'(idle), 32'd1);
        reset = 1'b0;

        // RAW on rd=5, cleared by an ALU write
        set_issue(1, 0, 0, 0, 0, 5, 1, 0);
        cycle();
        set_issue(1, 5, 1, 0, 0, 0, 0, 0);
        #1 check("raw stall", 32'(issue_ready), 32'd0);
        alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 1'b0;
        check("raw WE3", 32'(WE3), 32'd1);
        check("raw A3", 32'(A3), 32'd5);
        check("raw WD3", WD3, 32'hDEADBEEF);
        check("raw busy5", 32'(busy_vec[5]), 32'd0);
        check("raw ready after write", 32'(issue_ready), 32'd1);
        cycle();

        // ALU/load collision: ALU first, load next cycle
        set_issue(1, 0, 0, 0, 0, 3, 1, 0);
        cycle();
        set_issue(1, 0, 0, 0, 0, 7, 1, 1);
        cycle();
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);
        alu_valid = 1'b1; alu_rd = 3; alu_data = 32'h1234_5678;
        ld_valid  = 1'b1; ld_rd  = 7; ld_data  = 32'hCAFE_F00D;
        #1 check("collision ld_ready", 32'(ld_ready), 32'd0);
        cycle();
        check("collision first A3", 32'(A3), 32'd3);
        check("collision first WD3", WD3, 32'h1234_5678);
        alu_valid = 1'b0;
        cycle();
        check("collision second A3", 32'(A3), 32'd7);
        check("collision second WD3", WD3, 32'hCAFE_F00D);

        // Load budget
        for (int i = 0; i < 4; i++) begin
            set_issue(1, 0, 0, 0, 0, 5'(10 + i), 1, 1);
            cycle();
        end
        set_issue(1, 0, 0, 0, 0, 14, 1, 1);
        #1 check("ld budget stall", 32'(issue_ready), 32'd0);
        ld_valid = 1'b1; ld_rd = 10; ld_data = $urandom;
        cycle();
        ld_valid = 1'b1; ld_rd = 11; ld_data = $urandom;
        cycle();
        set_issue(1, 0, 0, 0, 0, 0, 1, 1);
        #1 check("ld issue+hs keeps count", 32'(issue_ready), 32'd1);
        cycle();
        set_issue(1, 0, 0, 0, 0, 15, 1, 1);
        #1 check("ld budget full again", 32'(issue_ready), 32'd0);
        drain();

        // x0 and WAW
        set_issue(1, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        check("x0 not busy", 32'(busy_vec), 32'd0);
        set_issue(1, 0, 0, 0, 0, 9, 1, 0);
        cycle();
        #1 check("waw stall", 32'(issue_ready), 32'd0);
        cycle();
        alu_valid = 1'b1; alu_rd = 9; alu_data = $urandom;
        #1 check("waw same-cycle clear stalls", 32'(issue_ready), 32'd0);
        cycle();
        alu_valid = 1'b0;
        #1 check("waw ready after write", 32'(issue_ready), 32'd1);
        cycle();
        drain();

        // Out-of-range addresses
        set_issue(1, 0, 0, 0, 0, 20, 1, 0);
        #1 check("oor rd ready", 32'(issue_ready), 32'd1);
        cycle();
        check("oor no busy", 32'(busy_vec), 32'd0);
        set_issue(1, 20, 1, 20, 1, 0, 0, 0);
        #1 check("oor rs ready", 32'(issue_ready), 32'd1);
        cycle();
        drain();

        // Reset in the middle of work: busy={1,2}, two loads out, WE3 in flight
        set_issue(1, 0, 0, 0, 0, 1, 1, 0);
        cycle();
        set_issue(1, 0, 0, 0, 0, 2, 1, 1);
        cycle();
        set_issue(1, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);
        alu_valid = 1'b1; alu_rd = 0; alu_data = 32'h55;
        cycle();
        alu_valid = 1'b0;
        check("pre-reset busy_vec", 32'(busy_vec), 32'h0006);
        check("pre-reset WE3", 32'(WE3), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid reset busy_vec", 32'(busy_vec), 32'd0);
        check("mid reset WE3", 32'(WE3), 32'd0);
        check("mid reset idle", 32'(idle), 32'd1);
        model_reset();
        ld_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic ld_i;
            ld_i = ($urandom_range(0, 3) == 0);
            set_issue($urandom_range(0, 2) != 0,
                      5'($urandom_range(0, 19)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 19)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 19)),
                      ld_i ? 1'b1 : 1'($urandom_range(0, 1)), ld_i);
            alu_valid = 1'b0;
            if (pend_alu.size() != 0 && $urandom_range(0, 2) == 0) begin
                alu_valid = 1'b1;
                alu_rd    = 5'(pend_alu[$urandom_range(0, pend_alu.size() - 1)]);
                alu_data  = $urandom;
            end
            if (!ld_valid && pend_ld.size() != 0 && $urandom_range(0, 1) == 1) begin
                ld_valid = 1'b1;
                ld_rd    = 5'(pend_ld[0]);
                ld_data  = $urandom;
            end
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
